// File: rtl/serializer_pkg.sv
// Shared types and defaults for the pattern serializer and its bit-period divider.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_TICK_DIV = 4;

    // A divide-by-1 divider still needs one flop so the count vector is never zero-width.
    function automatic int div_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_serializer_tick_gen.sv
// Mod-TICK_DIV counter: tick on count 0, wrap on count TICK_DIV-1; sync clear beats enable.
module tick_gen
    import serializer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic wrap
);

    localparam int DIV_W = div_width(TICK_DIV);

    logic [DIV_W-1:0] count;

    assign tick = (count == '0);
    assign wrap = (count == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// Latches a WIDTH-bit pattern on start and shifts it out on x, TICK_DIV clocks per bit.
// SERIALIZER_LSB_FIRST_EN selects LSB-first order; default build is MSB first.
module pattern_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             x,
    output logic             bit_tick,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef SERIALIZER_LSB_FIRST_EN
    localparam int OUT_BIT = 0;
`else
    localparam int OUT_BIT = WIDTH - 1;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             load;
    logic             advance;
    logic             div_clear;
    logic             div_en;
    logic             div_tick;
    logic             div_wrap;
    logic             x_next;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .enable(div_en),
        .tick  (div_tick),
        .wrap  (div_wrap)
    );

`ifdef SERIALIZER_LSB_FIRST_EN
    assign shifted = {1'b0, shreg[WIDTH-1:1]};
`else
    assign shifted = {shreg[WIDTH-2:0], 1'b0};
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        div_clear  = 1'b0;
        div_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                    div_clear  = 1'b1;
                end
            end
            SHIFT: begin
                div_en = 1'b1;
                if (div_wrap) begin
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state_next = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        if (load) begin
            shreg_next   = data_in;
            bit_cnt_next = '0;
        end else if (advance) begin
            shreg_next   = shifted;
            bit_cnt_next = bit_cnt + CNT_W'(1);
        end
        // x is computed from next-cycle state so it lands in a flop aligned with busy.
        x_next = (state_next == SHIFT) ? shreg_next[OUT_BIT] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            x       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            x       <= x_next;
            busy    <= (state_next == SHIFT);
            done    <= (state_next == DONE);
        end
    end

    // Both operands are flops, so the strobe has no path from any input.
    assign bit_tick = busy & div_tick;

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial bit source that drives the serial input `x` of the consecutive-sequence detector. It latches a WIDTH-bit test pattern on a start request and shifts it out one bit per bit period, with a programmable number of clock cycles per bit. A one-cycle `bit_tick` strobe accompanies each new bit, so the downstream detector can advance exactly once per bit. `busy` and `done` give the controlling logic a simple start/complete handshake.

## Interface
- `WIDTH`, default 8: pattern length in bits; must be ≥ 2.
- `TICK_DIV`, default 4: clock cycles per bit period; must be ≥ 1.
- `clk`  input  1  system clock; all state changes occur on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to serialize `data_in`; sampled only in IDLE.
- `data_in`  input  WIDTH  pattern, captured on the cycle `start` is accepted.
- `x`  output  1  serial bit to the detector; registered.
- `bit_tick`  output  1  one-cycle strobe on the first cycle of every bit period.
- `busy`  output  1  high while bits are being shifted out.
- `done`  output  1  one-cycle pulse after the last bit period ends.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `x`=0, `busy`=0. `start`=1 captures `data_in` into the shift register, clears the bit counter and the divider, and moves to SHIFT.
- SHIFT: `x` presents the current bit. The divider counts 0..TICK_DIV-1, and `bit_tick`=1 when the divider is 0. When the divider wraps:
  - If the bit counter equals WIDTH-1, go to DONE.
  - Otherwise shift the register, increment the bit counter, and restart the divider.
- DONE: `done`=1, `busy`=0, `x`=0 for exactly one cycle, then return to IDLE.
- `start` is ignored in SHIFT and DONE; it is not queued. `data_in` changes after capture have no effect.
- Bit order is MSB first unless the configuration macro below is defined.
- Bit counter width is $clog2(WIDTH); divider width is $clog2(TICK_DIV), minimum 1 bit.
- With TICK_DIV=1, the divider is constantly 0 and `bit_tick` is high on every SHIFT cycle.

## Timing
- Reset, asynchronous and checked at any time, including mid-SHIFT: state=IDLE, `x`=0, `bit_tick`=0, `busy`=0, `done`=0, shift register, bit counter and divider all cleared. Operation resumes on the first rising edge after `reset` deasserts.
- `start` is accepted at rising edge k. During cycle k+1: `busy`=1, `x`=bit0, `bit_tick`=1.
- Bit i is held on `x` for cycles k+1+i·TICK_DIV through k+(i+1)·TICK_DIV.
- `done`=1 during cycle k+1+WIDTH·TICK_DIV.
- The earliest next accepted `start` is at edge k+2+WIDTH·TICK_DIV (the first IDLE cycle).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SERIALIZER_LSB_FIRST_EN`:
  - Defined: bits are shifted out LSB first (`data_in[0]` first).
  - Undefined: MSB first (`data_in[WIDTH-1]` first).
- Handshake, timing and reset behaviour are identical in both builds.

## Structure
- Shared package `serializer_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default constants for WIDTH and TICK_DIV.
- One sub-module, `tick_gen`: a mod-TICK_DIV counter with synchronous clear and enable that outputs `tick` when its count is 0 and `wrap` when its count is TICK_DIV-1. It is reset by the same asynchronous active-high `reset`.

## Test plan
- Reset check: hold `reset`=1 for 3 cycles, then release → `x`, `bit_tick`, `busy`, `done` all 0, and they stay 0 with `start`=0.
- Basic frame: WIDTH=8, TICK_DIV=4, `data_in`=8'hE4, `start` at edge k →
  - `x` sequence is 1,1,1,0,0,1,0,0, each bit held for 4 cycles;
  - `bit_tick` pulses at k+1, k+5, …, k+29;
  - `done` is high only at cycle k+33.
- TICK_DIV=1, `data_in`=8'h0F → `bit_tick` high for 8 consecutive cycles, `x`=0,0,0,0,1,1,1,1, and `done` the cycle after the last bit.
- Ignored start: pulse `start` with `data_in`=8'hFF in the middle of the 8'hE4 frame and during its DONE cycle → serialized output is unchanged (still 8'hE4) and no second frame begins.
- Reset mid-frame: assert `reset` after bit 3 of 8'hE4 → `x`, `busy`, `bit_tick` go to 0 immediately and `done` never pulses. A new `start` after release with 8'h81 serializes cleanly from bit 0.
- `SERIALIZER_LSB_FIRST_EN` build, `data_in`=8'hE4 → `x`=0,0,1,0,0,1,1,1, with timing identical to the basic-frame scenario.
